g_eval_sweep: RTL

Sequencer that drives the four select lines of the G evaluation cone, which is comprised of `g116`, `g119`, `g144` and `g145`. It waits a fixed settle time for the combinational path to resolve, then samples `g217`. It repeats this for every enabled select combination and returns the 16 sampled bits as one result word over a valid/ready handshake. It sits directly around G: its `sel_out` feeds G's select inputs and its `eval_in` consumes G's `g217`. Downstream checkers compare the result word against a golden vector during ECO validation.

---
 rtl/g_eval_pkg.sv | 20 ++
 rtl/g_eval_sweep_if.sv | 36 +++
 rtl/g_eval_next_idx.sv | 34 +++
 rtl/g_eval_sweep.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/g_eval_pkg.sv
// rtl/g_eval_pkg.sv - shared types and constants for the G evaluation-cone sweeper
package g_eval_pkg;

  localparam int G_EVAL_NCOMB = 16;
  localparam int G_EVAL_SELW  = 4;
  localparam int G_EVAL_CNTW  = 4;

  // Bit positions of the G select inputs inside sel_out
  localparam int SEL_G116 = 0;
  localparam int SEL_G119 = 1;
  localparam int SEL_G144 = 2;
  localparam int SEL_G145 = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } g_eval_state_t;

endpackage

// File: rtl/g_eval_sweep_if.sv
// rtl/g_eval_sweep_if.sv - start/result handshake bundle; res_parity exists only with G_EVAL_PARITY_EN
interface g_eval_sweep_if;
  import g_eval_pkg::*;

  logic                    start;
  logic                    start_ready;
  logic [G_EVAL_NCOMB-1:0] cfg_mask;
  logic                    res_valid;
  logic                    res_ready;
  logic [G_EVAL_NCOMB-1:0] res_data;
  logic                    res_aborted;
`ifdef G_EVAL_PARITY_EN
  logic                    res_parity;

  modport master (
    output start, cfg_mask, res_ready,
    input  start_ready, res_valid, res_data, res_aborted, res_parity
  );

  modport slave (
    input  start, cfg_mask, res_ready,
    output start_ready, res_valid, res_data, res_aborted, res_parity
  );
`else
  modport master (
    output start, cfg_mask, res_ready,
    input  start_ready, res_valid, res_data, res_aborted
  );

  modport slave (
    input  start, cfg_mask, res_ready,
    output start_ready, res_valid, res_data, res_aborted
  );
`endif

endinterface

// File: rtl/g_eval_next_idx.sv
// rtl/g_eval_next_idx.sv - finds the lowest set mask bit strictly above idx (idx = all-ones means -1)
module g_eval_next_idx
  import g_eval_pkg::*;
(
  input  logic [G_EVAL_NCOMB-1:0] mask_i,
  input  logic [G_EVAL_SELW:0]    idx_i,
  output logic [G_EVAL_SELW-1:0]  nxt_o,
  output logic                    none_o
);

  localparam logic [G_EVAL_NCOMB-1:0] ONE = G_EVAL_NCOMB'(1);

  // idx+1 in 5 bits: -1 wraps to 0 (search everything), 15 becomes 16 (search nothing)
  logic [G_EVAL_SELW:0]    base;
  logic [G_EVAL_NCOMB-1:0] low;
  logic [G_EVAL_NCOMB-1:0] cand;

  assign base = idx_i + 5'd1;
  assign low  = (ONE << base) - ONE;
  assign cand = mask_i & ~low;

  // Priority encode: scan downwards so the lowest candidate wins
  always_comb begin
    nxt_o  = '0;
    none_o = 1'b1;
    for (int i = G_EVAL_NCOMB - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt_o  = G_EVAL_SELW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/g_eval_sweep.sv
// rtl/g_eval_sweep.sv - sweeps G select combinations, samples g217 after settling; optional G_EVAL_PARITY_EN adds res_parity
module g_eval_sweep
  import g_eval_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  g_eval_sweep_if.slave          bus,
  input  logic                   abort_i,
  output logic [G_EVAL_SELW-1:0] sel_out_o,
  input  logic                   eval_in_i,
  output logic                   busy_o
);

  localparam logic [G_EVAL_CNTW-1:0] SETTLE_C = G_EVAL_CNTW'(SETTLE);

  g_eval_state_t           state_q, state_d;
  logic [G_EVAL_NCOMB-1:0] mask_q, mask_d;
  logic [G_EVAL_NCOMB-1:0] res_q, res_d;
  logic [G_EVAL_SELW-1:0]  idx_q, idx_d;
  logic [G_EVAL_CNTW-1:0]  cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    aborted_q, aborted_d;

  logic                    start_ready;
  logic                    accept;
  logic [G_EVAL_NCOMB-1:0] srch_mask;
  logic [G_EVAL_SELW:0]    srch_idx;
  logic [G_EVAL_SELW-1:0]  nxt;
  logic                    none;

  assign start_ready = !busy_q && !valid_q;
  assign accept      = bus.start && start_ready;

  // One finder serves both uses: first index straight from cfg_mask in IDLE, advance from mask_q otherwise
  assign srch_mask = (state_q == IDLE) ? bus.cfg_mask : mask_q;
  assign srch_idx  = (state_q == IDLE) ? '1 : {1'b0, idx_q};

  g_eval_next_idx u_next_idx (
    .mask_i (srch_mask),
    .idx_i  (srch_idx),
    .nxt_o  (nxt),
    .none_o (none)
  );

  // Next-state and next-output computation for the sweep FSM
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    res_d     = res_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d    = bus.cfg_mask;
          res_d     = '0;
          aborted_d = 1'b0;
          if (!none) begin
            idx_d   = nxt;
            cnt_d   = SETTLE_C;
            busy_d  = 1'b1;
            state_d = EVAL;
          end else begin
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      EVAL: begin
        if (abort_i) begin
          // The sample due this cycle is dropped; earlier samples stay
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end else if (cnt_q == '0) begin
          res_d[idx_q] = eval_in_i;
          if (none) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            idx_d = nxt;
            cnt_d = SETTLE_C;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      aborted_q <= aborted_d;
    end
  end

  assign sel_out_o       = idx_q;
  assign busy_o          = busy_q;
  assign bus.start_ready = start_ready;
  assign bus.res_valid   = valid_q;
  assign bus.res_data    = res_q;
  assign bus.res_aborted = aborted_q;

`ifdef G_EVAL_PARITY_EN
  logic parity_q;

  // Parity tracks every update of the result register so it is valid with res_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^res_d;
    end
  end

  assign bus.res_parity = parity_q;
`endif

endmodule
